// File: rtl/bp_cce_mem_payload_responder.sv
// bp_cce_mem_payload_responder
//   Memory-side endpoint for the CCE memory command/response path. Each accepted
//   command is held for a fixed access latency and then returned, in command
//   order, with paddr, write flag and the opaque MSHR payload echoed bit-exact.
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   cmd_v_i / cmd_ready_o    command handshake (accept = v & ready)
//   cmd_wr_i, cmd_paddr_i,   command fields
//   cmd_payload_i
//   resp_v_o / resp_yumi_i   response handshake (yumi only while valid)
//   resp_wr_o, resp_paddr_o, head entry fields, meaningful only while resp_v_o
//   resp_payload_o
//   outstanding_o            number of entries currently held
module bp_cce_mem_payload_responder #(
  parameter int unsigned paddr_width_p = 40,
  parameter int unsigned mshr_width_p  = 64,
  parameter int unsigned els_p         = 4,
  parameter int unsigned latency_p     = 8,
  localparam int unsigned ptr_w   = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int unsigned cnt_w   = $clog2(latency_p + 1),
  localparam int unsigned count_w = $clog2(els_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     cmd_v_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_wr_i,
  input  logic [paddr_width_p-1:0] cmd_paddr_i,
  input  logic [mshr_width_p-1:0]  cmd_payload_i,
  output logic                     resp_v_o,
  input  logic                     resp_yumi_i,
  output logic                     resp_wr_o,
  output logic [paddr_width_p-1:0] resp_paddr_o,
  output logic [mshr_width_p-1:0]  resp_payload_o,
  output logic [count_w-1:0]       outstanding_o
);

  logic                     entry_wr      [els_p];
  logic [paddr_width_p-1:0] entry_paddr   [els_p];
  logic [mshr_width_p-1:0]  entry_payload [els_p];
  logic [cnt_w-1:0]         entry_cnt     [els_p];

  logic [ptr_w-1:0]   rd_ptr;
  logic [ptr_w-1:0]   wr_ptr;
  logic [count_w-1:0] count;
  logic               accept;
  logic               deq;

  // Pointer increment with wrap at els_p-1 (els_p need not be a power of 2).
  function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(els_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  // Entry idx is live when its distance from the read pointer is below count.
  function automatic logic is_occ(input int unsigned idx,
                                  input logic [ptr_w-1:0] rd,
                                  input logic [count_w-1:0] cnt);
    int unsigned off;
    off = (idx >= 32'(rd)) ? idx - 32'(rd) : idx + els_p - 32'(rd);
    return off < 32'(cnt);
  endfunction

  // Full check deliberately ignores resp_yumi_i: no same-cycle full bypass.
  assign cmd_ready_o    = ~reset_i & (count != count_w'(els_p));
  assign accept         = cmd_v_i & cmd_ready_o;
  assign deq            = resp_yumi_i & resp_v_o;

  assign resp_v_o       = (count != '0) & (entry_cnt[rd_ptr] == '0);
  assign resp_wr_o      = entry_wr[rd_ptr];
  assign resp_paddr_o   = entry_paddr[rd_ptr];
  assign resp_payload_o = entry_payload[rd_ptr];
  assign outstanding_o  = count;

  // Control state: pointers, occupancy and per-entry latency countdown.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < els_p; i++) begin
        entry_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < els_p; i++) begin
        if (is_occ(i, rd_ptr, count) && (entry_cnt[i] != '0)) begin
          entry_cnt[i] <= entry_cnt[i] - cnt_w'(1);
        end
      end
      // The written slot is free, so this load never collides with a decrement.
      if (accept) begin
        entry_cnt[wr_ptr] <= cnt_w'(latency_p - 1);
        wr_ptr            <= next_ptr(wr_ptr);
      end
      if (deq) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      count <= count + count_w'(accept) - count_w'(deq);
    end
  end

  // Echoed command fields need no reset; they are only observed while valid.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      entry_wr[wr_ptr]      <= cmd_wr_i;
      entry_paddr[wr_ptr]   <= cmd_paddr_i;
      entry_payload[wr_ptr] <= cmd_payload_i;
    end
  end

  // Handshake protocol and occupancy sanity.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(resp_yumi_i && !resp_v_o));
      assert (count <= count_w'(els_p));
    end
  end

endmodule
